ace_ps2_keyboard: RTL
=====================

Name: ace_ps2_keyboard

Overview:
- Upstream stage of the Jupiter Ace core: turns raw PS/2 keyboard clock/data into the 8x5 key matrix that the core scans via `kbd_row`/`kbd_col`.
- Samples and filters PS/2 lines, deframes 11-bit frames, and tracks E0/F0 prefixes.
- Holds key-down state per matrix position and answers row scans combinationally.

Parameters:
- FILTER_LEN, 8: consecutive identical `clk` samples needed to accept a new `ps2_clk` level.
- TIMEOUT, 16384: `clk` cycles without a `ps2_clk` falling edge before a partial frame is discarded.

Ports:
- clk  in  1  system clock, same as core.
- reset_n  in  1  asynchronous, active-low reset.
- ps2_clk  in  1  raw PS/2 clock from pad.
- ps2_data  in  1  raw PS/2 data from pad.
- kbd_row  in  8  row select = CPU A[15:8]; bit low selects row.
- kbd_col  out  5  column result, active-low; 1 = no key.
- scan_valid  out  1  one-cycle strobe per accepted byte.
- scan_code  out  8  last accepted byte.
- frame_err  out  1  one-cycle strobe on parity/start/stop error or timeout.

Behaviour:
- Reset values: all matrix bits 0 (released), `kbd_col` = 5'b11111, `scan_valid` = 0, `scan_code` = 8'h00, `frame_err` = 0, FSM in IDLE, prefix flags cleared.
- Input conditioning:
  - Both PS/2 lines pass through a 2-flop synchronizer.
  - `ps2_clk` is filtered: level changes only after FILTER_LEN equal samples.
  - A falling edge of the filtered clock samples synced `ps2_data`.
- Frame FSM:
  - IDLE: on a sampled 0, go to DATA. A sampled 1 is ignored.
  - DATA: 8 bits, LSB first.
  - PARITY: data plus parity bit must hold an odd number of ones.
  - STOP: stop bit must be 1.
  - Valid frame: `scan_code` <= byte and `scan_valid` = 1 for one cycle, 2 cycles after the stop-bit edge.
  - Parity or stop failure: `frame_err` pulses; byte dropped; back to IDLE.
- Timeout: a counter clears on each filtered falling edge. Reaching TIMEOUT outside IDLE gives `frame_err` pulse and return to IDLE. Counter saturates and does not wrap.
- Prefix handling:
  - E0 sets `ext`; F0 sets `rel`. Both persist until the next non-prefix byte.
  - A non-prefix byte clears both flags after use.
  - E0 F0 and F0 E0 orders are both accepted.
- Key update: a non-prefix byte maps to a matrix bit. Bit <= ~rel. Unmapped codes are ignored.
- Codes AA, FA, FE, EE (BAT/ack/resend/echo) are ignored and never touch the matrix.
- Code E1 (Pause) and its 7 following bytes are swallowed by a skip counter.
- Matrix, columns 0..4 (set-2 codes):
  - row0: SHIFT(12, 59), SYMSHIFT(14, E0 14), Z 1A, X 22, C 21
  - row1: A 1C, S 1B, D 23, F 2B, G 34
  - row2: Q 15, W 1D, E 24, R 2D, T 2C
  - row3: 1 16, 2 1E, 3 26, 4 25, 5 2E
  - row4: 0 45, 9 46, 8 3E, 7 3D, 6 36
  - row5: P 4D, O 44, I 43, U 3C, Y 35
  - row6: ENTER(5A, E0 5A), L 4B, K 42, J 3B, H 33
  - row7: SPACE 29, M 3A, N 31, B 32, V 2A
- SHIFT and SYMSHIFT are the OR of their source keys; each source has its own state bit.
- Column output is combinational: `kbd_col[c]` = ~OR over rows r with `kbd_row[r]` = 0 of `key[r][c]`.
  - Several rows low: results AND together (active-low).
  - No row selected: `kbd_col` = 5'b11111.
- Reset mid-frame clears everything immediately. The next frame is accepted only after its start bit.

Optional Feature:
- Macro ACE_KBD_COMPOUND_EN.
- Defined: compound keys drive extra virtual state bits that are ORed into the matrix.
  - Backspace 66 = SHIFT + 0.
  - E0 6B left = SHIFT + 5.
  - E0 72 down = SHIFT + 6.
  - E0 75 up = SHIFT + 7.
  - E0 74 right = SHIFT + 8.
  - Releasing a compound key does not clear a real SHIFT held independently.
- Undefined: these codes are unmapped and ignored.

Test Plan:
- Press Z: frame 1A with correct parity, then `kbd_row` = 8'hFE -> `kbd_col` = 5'b11011, `scan_valid` pulse with `scan_code` = 8'h1A. Then F0 1A -> `kbd_col` = 5'b11111.
- Multi-row scan: hold Q (row2) and SPACE (row7), `kbd_row` = 8'h7B -> `kbd_col` = 5'b11110; `kbd_row` = 8'hFF -> 5'b11111.
- Extended key: E0 14 then `kbd_row` = 8'hFE -> `kbd_col` = 5'b11101. LCtrl 14 press then E0 F0 14 -> bit stays pressed until F0 14.
- Errors: frame 1A with wrong parity -> `frame_err` pulse, no `scan_valid`, matrix unchanged. Stop after 5 bits for TIMEOUT+1 cycles -> `frame_err`, FSM IDLE, next valid frame 1C sets A (row1 col0).
- Glitch and reset: a `ps2_clk` low glitch shorter than FILTER_LEN cycles -> no bit sampled. `reset_n` low while G held mid-frame -> `kbd_col` = 5'b11111 at once, `scan_code` = 0.
- ACE_KBD_COMPOUND_EN defined: E0 75 -> row0 col0 and row4 col3 pressed (`kbd_row` = 8'hEE -> `kbd_col` = 5'b10110). E0 F0 75 while 12 still held -> SHIFT remains pressed. Macro undefined: E0 75 -> no change.

Source files
------------

// File: rtl/ace_ps2_keyboard.sv
// PS/2 set-2 keyboard front end for the Jupiter Ace: deframes scan codes into the 8x5 key matrix.
// Define ACE_KBD_COMPOUND_EN to map cursor keys and backspace onto SHIFT+digit combinations.
module ace_ps2_keyboard #(
    parameter int unsigned FILTER_LEN = 8,
    parameter int unsigned TIMEOUT    = 16384
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    input  logic [7:0] kbd_row_i,
    output logic [4:0] kbd_col_o,
    output logic       scan_valid_o,
    output logic [7:0] scan_code_o,
    output logic       frame_err_o
);

    localparam int unsigned FltW = $clog2(FILTER_LEN + 1);
    localparam int unsigned ToW  = $clog2(TIMEOUT + 1);
`ifdef ACE_KBD_COMPOUND_EN
    localparam int unsigned NumKeys = 48;
`else
    localparam int unsigned NumKeys = 43;
`endif

    typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

    logic [1:0]        clk_sync_q, data_sync_q;
    logic              filt_q, filt_d, filt_prev_q;
    logic [FltW-1:0]   flt_cnt_q, flt_cnt_d;
    logic [ToW-1:0]    to_cnt_q, to_cnt_d;
    state_e            state_q, state_d;
    logic [7:0]        shift_q, shift_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic              par_ok_q, par_ok_d;
    logic              done_q, done_d, err_q, err_d;
    logic [7:0]        byte_q;
    logic              ext_q, ext_d, rel_q, rel_d;
    logic [2:0]        skip_q, skip_d;
    logic [NumKeys-1:0] keys_q, keys_d;
    logic              scan_valid_q, frame_err_q;
    logic [7:0]        scan_code_q;
    logic              fall, data_s, timeout;
    logic              key_hit;
    logic [5:0]        key_idx;
    logic [7:0][4:0]   mat;
    logic [4:0]        col_hit;

    assign data_s  = data_sync_q[1];
    assign fall    = filt_prev_q & ~filt_q;
    assign timeout = (state_q != StIdle) && (to_cnt_q >= ToW'(TIMEOUT)) && !fall;

    // Filtered level flips only after FILTER_LEN consecutive samples disagree with it.
    always_comb begin
        filt_d    = filt_q;
        flt_cnt_d = '0;
        if (clk_sync_q[1] != filt_q) begin
            if (flt_cnt_q == FltW'(FILTER_LEN - 1)) begin
                filt_d = clk_sync_q[1];
            end else begin
                flt_cnt_d = flt_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        if (fall) begin
            to_cnt_d = '0;
        end else if (to_cnt_q < ToW'(TIMEOUT)) begin
            to_cnt_d = to_cnt_q + 1'b1;
        end else begin
            to_cnt_d = to_cnt_q;
        end
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        par_ok_d  = par_ok_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        if (timeout) begin
            state_d = StIdle;
            err_d   = 1'b1;
        end else if (fall) begin
            unique case (state_q)
                StIdle: begin
                    if (!data_s) begin
                        state_d   = StData;
                        bit_cnt_d = '0;
                    end
                end
                StData: begin
                    shift_d   = {data_s, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 3'd7) state_d = StParity;
                end
                StParity: begin
                    par_ok_d = ^{data_s, shift_q};
                    state_d  = StStop;
                end
                StStop: begin
                    state_d = StIdle;
                    if (data_s && par_ok_q) done_d = 1'b1;
                    else                    err_d  = 1'b1;
                end
            endcase
        end
    end

    // Codes absent here (including AA/FA/FE/EE) never touch the matrix.
    always_comb begin
        key_hit = 1'b1;
        key_idx = '0;
        case ({ext_q, byte_q})
            9'h012: key_idx = 6'd0;   9'h014: key_idx = 6'd1;   9'h01A: key_idx = 6'd2;
            9'h022: key_idx = 6'd3;   9'h021: key_idx = 6'd4;
            9'h01C: key_idx = 6'd5;   9'h01B: key_idx = 6'd6;   9'h023: key_idx = 6'd7;
            9'h02B: key_idx = 6'd8;   9'h034: key_idx = 6'd9;
            9'h015: key_idx = 6'd10;  9'h01D: key_idx = 6'd11;  9'h024: key_idx = 6'd12;
            9'h02D: key_idx = 6'd13;  9'h02C: key_idx = 6'd14;
            9'h016: key_idx = 6'd15;  9'h01E: key_idx = 6'd16;  9'h026: key_idx = 6'd17;
            9'h025: key_idx = 6'd18;  9'h02E: key_idx = 6'd19;
            9'h045: key_idx = 6'd20;  9'h046: key_idx = 6'd21;  9'h03E: key_idx = 6'd22;
            9'h03D: key_idx = 6'd23;  9'h036: key_idx = 6'd24;
            9'h04D: key_idx = 6'd25;  9'h044: key_idx = 6'd26;  9'h043: key_idx = 6'd27;
            9'h03C: key_idx = 6'd28;  9'h035: key_idx = 6'd29;
            9'h05A: key_idx = 6'd30;  9'h04B: key_idx = 6'd31;  9'h042: key_idx = 6'd32;
            9'h03B: key_idx = 6'd33;  9'h033: key_idx = 6'd34;
            9'h029: key_idx = 6'd35;  9'h03A: key_idx = 6'd36;  9'h031: key_idx = 6'd37;
            9'h032: key_idx = 6'd38;  9'h02A: key_idx = 6'd39;
            9'h059: key_idx = 6'd40;  9'h114: key_idx = 6'd41;  9'h15A: key_idx = 6'd42;
`ifdef ACE_KBD_COMPOUND_EN
            9'h066: key_idx = 6'd43;  9'h16B: key_idx = 6'd44;  9'h172: key_idx = 6'd45;
            9'h175: key_idx = 6'd46;  9'h174: key_idx = 6'd47;
`endif
            default: key_hit = 1'b0;
        endcase
    end

    always_comb begin
        keys_d = keys_q;
        ext_d  = ext_q;
        rel_d  = rel_q;
        skip_d = skip_q;
        if (done_q) begin
            if (skip_q != 3'd0) begin
                skip_d = skip_q - 1'b1;
            end else if (byte_q == 8'hE1) begin
                skip_d = 3'd7;
            end else if (byte_q == 8'hE0) begin
                ext_d = 1'b1;
            end else if (byte_q == 8'hF0) begin
                rel_d = 1'b1;
            end else begin
                if (key_hit) keys_d[key_idx] = ~rel_q;
                ext_d = 1'b0;
                rel_d = 1'b0;
            end
        end
    end

    always_comb begin
        for (int r = 0; r < 8; r++) mat[r] = keys_q[r*5 +: 5];
        mat[0][0] = mat[0][0] | keys_q[40];
        mat[0][1] = mat[0][1] | keys_q[41];
        mat[6][0] = mat[6][0] | keys_q[42];
`ifdef ACE_KBD_COMPOUND_EN
        mat[0][0] = mat[0][0] | (|keys_q[47:43]);
        mat[4][0] = mat[4][0] | keys_q[43];
        mat[3][4] = mat[3][4] | keys_q[44];
        mat[4][4] = mat[4][4] | keys_q[45];
        mat[4][3] = mat[4][3] | keys_q[46];
        mat[4][2] = mat[4][2] | keys_q[47];
`endif
        col_hit = '0;
        for (int r = 0; r < 8; r++) begin
            if (!kbd_row_i[r]) col_hit = col_hit | mat[r];
        end
    end

    assign kbd_col_o    = ~col_hit;
    assign scan_valid_o = scan_valid_q;
    assign scan_code_o  = scan_code_q;
    assign frame_err_o  = frame_err_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            clk_sync_q   <= 2'b11;
            data_sync_q  <= 2'b11;
            filt_q       <= 1'b1;
            filt_prev_q  <= 1'b1;
            flt_cnt_q    <= '0;
            to_cnt_q     <= '0;
            state_q      <= StIdle;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            par_ok_q     <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            byte_q       <= '0;
            ext_q        <= 1'b0;
            rel_q        <= 1'b0;
            skip_q       <= '0;
            keys_q       <= '0;
            scan_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            scan_code_q  <= '0;
        end else begin
            clk_sync_q   <= {clk_sync_q[0], ps2_clk_i};
            data_sync_q  <= {data_sync_q[0], ps2_data_i};
            filt_q       <= filt_d;
            filt_prev_q  <= filt_q;
            flt_cnt_q    <= flt_cnt_d;
            to_cnt_q     <= to_cnt_d;
            state_q      <= state_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            par_ok_q     <= par_ok_d;
            done_q       <= done_d;
            err_q        <= err_d;
            if (done_d) byte_q <= shift_q;
            ext_q        <= ext_d;
            rel_q        <= rel_d;
            skip_q       <= skip_d;
            keys_q       <= keys_d;
            scan_valid_q <= done_q;
            frame_err_q  <= err_q;
            if (done_q) scan_code_q <= byte_q;
        end
    end

endmodule
